// File: rtl/cic_interp_pkg.sv
// Shared SDR package: default widths and helpers used by the CIC
// interpolator and its receive-side decimator twin.
package cic_interp_pkg;

  localparam int IN_W_DEF   = 8;
  localparam int OUT_W_DEF  = 8;
  localparam int WIDTH_DEF  = 38;
  localparam int STAGES_DEF = 3;
  localparam int RATIO_W    = 16;

  typedef logic [RATIO_W-1:0] ratio_t;

  // Unity DC gain for an N-stage interpolator drops (N-1)*log2(R) LSBs.
  function automatic int calc_out_lsb(input int stages, input int log2_r);
    return (stages - 1) * log2_r;
  endfunction

  function automatic ratio_t clamp_ratio(input ratio_t r);
    return (r < ratio_t'(2)) ? ratio_t'(2) : r;
  endfunction

endpackage

// File: rtl/cic_interp_if.sv
// Sample-side handshake and full-rate output bundle of the CIC interpolator.
interface cic_interp_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  import cic_interp_pkg::*;

  ratio_t           interpolation_ratio;
  logic [IN_W-1:0]  s_data;
  logic             s_valid;
  logic             s_ready;
  logic [OUT_W-1:0] d_out;
  logic             d_valid;
  logic             underrun;

  modport master (
    output interpolation_ratio, s_data, s_valid,
    input  s_ready, d_out, d_valid, underrun
  );

  modport slave (
    input  interpolation_ratio, s_data, s_valid,
    output s_ready, d_out, d_valid, underrun
  );

endinterface

// File: rtl/cic_interp_integrator.sv
// One full-rate CIC integrator stage: wrapping accumulator of WIDTH bits.
module cic_integrator #(
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  // Modulo-2^WIDTH wrap is intentional; the comb section cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: low-rate combs, zero stuffing, full-rate integrators.
module cic_interp
  import cic_interp_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int STAGES  = STAGES_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OUT_LSB = calc_out_lsb(STAGES_DEF, 10)
) (
  input logic         clk,
  input logic         rst,
  cic_interp_if.slave bus
);

  localparam int FILL_W = RATIO_W + 2;

  ratio_t             cnt;
  ratio_t             r_eff;
  ratio_t             ratio_now;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_target;
  logic               strobe;
  logic               stuff_en;
  logic               d_valid_q;
  logic               underrun_q;
  logic [WIDTH-1:0]   comb_in;
  logic [WIDTH-1:0]   stuff;
  logic [WIDTH-1:0]   comb_dly [STAGES];
  logic [WIDTH-1:0]   comb_val [STAGES+1];
  logic [WIDTH-1:0]   integ_in [STAGES];
  logic [WIDTH-1:0]   integ    [STAGES];
  logic [OUT_W-1:0]   d_out_q;

  assign ratio_now    = clamp_ratio(bus.interpolation_ratio);
  assign strobe       = (cnt == r_eff - ratio_t'(1));
  assign bus.s_ready  = strobe;
  assign bus.d_out    = d_out_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.underrun = underrun_q;

  // Comb chain is only sampled on strobe cycles, so it may be multicycled.
  always_comb begin
    comb_in = '0;
    if (bus.s_valid) begin
      comb_in = {{(WIDTH-IN_W){bus.s_data[IN_W-1]}}, bus.s_data};
    end
    comb_val[0] = comb_in;
    for (int k = 0; k < STAGES; k++) begin
      comb_val[k+1] = comb_val[k] - comb_dly[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      r_eff       <= ratio_now;
      fill_target <= {1'b0, ratio_now, 1'b0} + FILL_W'(STAGES + 2);
      fill        <= '0;
      stuff       <= '0;
      stuff_en    <= 1'b0;
      underrun_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        comb_dly[k] <= '0;
      end
    end else begin
      stuff_en <= strobe;
      if (strobe) begin
        cnt   <= '0;
        r_eff <= ratio_now;
        stuff <= comb_val[STAGES];
        for (int k = 0; k < STAGES; k++) begin
          comb_dly[k] <= comb_val[k];
        end
        if (!bus.s_valid) begin
          underrun_q <= 1'b1;
        end
      end else begin
        cnt <= cnt + ratio_t'(1);
      end
      if (!d_valid_q) begin
        fill <= fill + FILL_W'(1);
        if (fill == fill_target - FILL_W'(1)) begin
          d_valid_q <= 1'b1;
        end
      end
    end
  end

  // The comb result enters the integrators for exactly one cycle per period.
  always_comb begin
    integ_in[0] = stuff_en ? stuff : '0;
    for (int k = 1; k < STAGES; k++) begin
      integ_in[k] = integ[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_integ
    cic_integrator #(
      .WIDTH (WIDTH)
    ) u_integ (
      .clk (clk),
      .rst (rst),
      .din (integ_in[k]),
      .acc (integ[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= integ[STAGES-1][OUT_LSB +: OUT_W];
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp: closed-form CIC reference model,
// strobe-period table and hand-written corner-case sequences.
module tb_cic_interp;
  import cic_interp_pkg::*;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 8;
  localparam int STAGES  = 3;
  localparam int WIDTH   = 38;
  localparam int OUT_LSB = 8;

  typedef struct {
    int ratio;
    int first_exp;
    int period_exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cic_interp_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  cic_interp #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .STAGES  (STAGES),
    .WIDTH   (WIDTH),
    .OUT_LSB (OUT_LSB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model state: cycle index since reset release, expected strobe schedule,
  // and the list of (cycle, comb value) impulses fed to the integrators.
  int     n;
  int     next_strobe;
  int     r0;
  bit     under_exp;
  longint ev_t[$];
  longint ev_c[$];
  longint x1, x2, x3;
  int     obs[$];
  int     checks;
  int     passes;
  vec_t   vecs[6];

  function automatic int clampr(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  function automatic int obs_at(input int i);
    return (obs.size() > i) ? obs[i] : -1;
  endfunction

  // Three cascaded running sums of an impulse c at cycle t give c*C(n-t-3,2)
  // at the output register (one cycle stuffing + three integrators + output).
  function automatic logic [OUT_W-1:0] model_dout(input int cyc);
    longint     acc;
    longint     k;
    logic [63:0] u;
    acc = 0;
    for (int i = 0; i < ev_t.size(); i++) begin
      k = longint'(cyc) - ev_t[i] - 3;
      if (k >= 2) acc += ev_c[i] * ((k * (k - 1)) / 2);
    end
    u = acc;
    return u[OUT_LSB +: OUT_W];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkOutput();
    logic             e_ready, e_valid;
    logic [OUT_W-1:0] e_dout;
    e_ready = (n == next_strobe);
    e_valid = (n >= 2 * r0 + STAGES + 2);
    e_dout  = model_dout(n);
    checks++;
    if ({bus.s_ready, bus.d_valid, bus.underrun, bus.d_out} ===
        {e_ready, e_valid, under_exp, e_dout}) begin
      passes++;
    end else begin
      $display("[TB] FAIL cycle %0d: got s_ready=%b d_valid=%b underrun=%b d_out=%0d, expected s_ready=%b d_valid=%b underrun=%b d_out=%0d",
               n, bus.s_ready, bus.d_valid, bus.underrun, $signed(bus.d_out),
               e_ready, e_valid, under_exp, $signed(e_dout));
    end
    if (bus.s_ready === 1'b1) obs.push_back(n);
  endtask

  task automatic applyStimulus(input bit v, input logic [IN_W-1:0] d, input int r);
    logic signed [IN_W-1:0] sd;
    longint x;
    @(negedge clk);
    checkOutput();
    bus.s_valid             = v;
    bus.s_data              = d;
    bus.interpolation_ratio = ratio_t'(r);
    if (n == next_strobe) begin
      sd = d;
      x  = v ? longint'(sd) : 0;
      if (!v) under_exp = 1'b1;
      ev_t.push_back(n);
      ev_c.push_back(x - 3 * x1 + 3 * x2 - x3);
      x3 = x2;
      x2 = x1;
      x1 = x;
      next_strobe = n + clampr(r);
    end
    n++;
  endtask

  task automatic doReset(input int r);
    @(negedge clk);
    rst                     = 1'b1;
    bus.interpolation_ratio = ratio_t'(r);
    bus.s_valid             = 1'b0;
    bus.s_data              = '0;
    @(negedge clk);
    check("reset s_ready", bus.s_ready, 0);
    check("reset d_out", bus.d_out, 0);
    check("reset d_valid", bus.d_valid, 0);
    check("reset underrun", bus.underrun, 0);
    rst         = 1'b0;
    n           = 1;
    r0          = clampr(r);
    next_strobe = r0 - 1;
    under_exp   = 1'b0;
    x1 = 0; x2 = 0; x3 = 0;
    ev_t.delete();
    ev_c.delete();
    obs.delete();
  endtask

  initial begin
    int  cur_r;
    int  s;
    bit  seen;
    bus.interpolation_ratio = ratio_t'(2);
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    checks = 0;
    passes = 0;

    vecs[0] = '{ratio: 1,  first_exp: 1,  period_exp: 2};
    vecs[1] = '{ratio: 0,  first_exp: 1,  period_exp: 2};
    vecs[2] = '{ratio: 2,  first_exp: 1,  period_exp: 2};
    vecs[3] = '{ratio: 3,  first_exp: 2,  period_exp: 3};
    vecs[4] = '{ratio: 8,  first_exp: 7,  period_exp: 8};
    vecs[5] = '{ratio: 16, first_exp: 15, period_exp: 16};

    $display("[TB] strobe period table, s_valid held high");
    for (int i = 0; i < 6; i++) begin
      doReset(vecs[i].ratio);
      for (int c = 0; c < 3 * vecs[i].period_exp + 2; c++)
        applyStimulus(1'b1, IN_W'($urandom), vecs[i].ratio);
      check($sformatf("ratio %0d first strobe", vecs[i].ratio), obs_at(0), vecs[i].first_exp);
      check($sformatf("ratio %0d period", vecs[i].ratio), obs_at(1) - obs_at(0), vecs[i].period_exp);
    end

    $display("[TB] DC input 100, R=16");
    doReset(16);
    for (int c = 0; c < 16 * 20; c++) applyStimulus(1'b1, IN_W'(100), 16);
    check("dc d_out", longint'($signed(bus.d_out)), 100);
    check("dc underrun", bus.underrun, 0);
    check("dc d_valid", bus.d_valid, 1);

    $display("[TB] impulse 127, R=16");
    doReset(16);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, (n <= 15) ? IN_W'(127) : IN_W'(0), 16);
      if (bus.d_out != '0) seen = 1'b1;
    end
    check("impulse response seen", seen, 1);
    check("impulse settles to 0", bus.d_out, 0);

    $display("[TB] underrun on strobe at cycle 47");
    doReset(16);
    for (int c = 0; c < 120; c++) begin
      applyStimulus(n != 47, IN_W'($urandom), 16);
      if (n == 48) check("underrun at strobe cycle", bus.underrun, 0);
      if (n == 49) check("underrun next cycle", bus.underrun, 1);
    end
    check("underrun sticky", bus.underrun, 1);

    $display("[TB] ratio 1 then 0, then 4 mid-period");
    doReset(1);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, IN_W'($urandom), 0);
    while (n != next_strobe) applyStimulus(1'b1, IN_W'($urandom), 0);
    s = n;
    applyStimulus(1'b1, IN_W'($urandom), 0);
    obs.delete();
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, IN_W'($urandom), 4);
    check("ratio change first strobe", obs_at(0) - s, 2);
    check("ratio change second strobe", obs_at(1) - s, 6);
    check("ratio change third strobe", obs_at(2) - s, 10);

    $display("[TB] randomized stream with ratio changes");
    doReset(5);
    cur_r = 5;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 3) cur_r = $urandom_range(0, 12);
      applyStimulus($urandom_range(0, 9) != 0, IN_W'($urandom), cur_r);
    end

    $display("[TB] reset during full-scale -128 burst, R=8");
    doReset(8);
    for (int c = 0; c < 40; c++) applyStimulus(1'b1, IN_W'(8'h80), 8);
    doReset(8);
    for (int c = 0; c < 20; c++) applyStimulus(1'b1, IN_W'(8'h80), 8);
    check("post-reset first strobe", obs_at(0), 7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
# cic_interp

CIC interpolator for the transmit path, mirroring the receive-side CIC decimator. It accepts low-rate signed baseband samples through a ready/valid handshake and produces one signed sample per `clk` at the full system rate. The full-rate output feeds the transmit mixer/upconverter, which uses the same NCO/LO as the receiver.

## Interface
- `IN_W`, 8, input sample width, signed two's complement
- `OUT_W`, 8, output sample width, signed
- `STAGES`, 3, number of comb stages and number of integrator stages (N)
- `WIDTH`, 38, internal register width; must be ≥ IN_W + STAGES·log2(Rmax)
- `OUT_LSB`, 20, LSB of the internal word routed to `d_out`; equals (STAGES−1)·log2(R) for unity DC gain (20 for R=1024, N=3)
- `clk`  in  1  system clock, the single clock domain; all logic is rising-edge
- `rst`  in  1  synchronous, active-high reset
- `interpolation_ratio`  in  16  R; sampled only at a strobe cycle; values 0 and 1 are treated as 2
- `s_data`  in  IN_W  input sample, signed
- `s_valid`  in  1  `s_data` is valid
- `s_ready`  out  1  one-cycle strobe; the sample is consumed in this cycle if `s_valid` is high
- `d_out`  out  OUT_W  interpolated sample, signed, updated every cycle
- `d_valid`  out  1  high once the pipeline is primed after reset
- `underrun`  out  1  sticky flag; set when a strobe finds `s_valid` low; cleared only by `rst`

## Operation
- Rate counter `cnt` counts 0..R−1 and wraps. The strobe occurs at `cnt == R−1`. `s_ready` is high exactly on strobe cycles.
- At each strobe:
  - Latch `R_eff` = max(`interpolation_ratio`, 2) for the next period.
  - If `s_valid` is high, the comb input is `s_data` sign-extended to WIDTH. Otherwise the comb input is 0 and `underrun` is set.
- Combs, differential delay 1: run combinationally across the N stages from per-stage delay registers. The delay registers update only on strobe cycles. The final comb result is registered into `stuff` on the cycle after the strobe.
- Zero stuffing: the integrator input equals `stuff` for exactly one cycle per period and 0 on all other cycles.
- Integrators: N cascaded registers, each `int[k] <= int[k] + int[k−1]`, updated every cycle. Arithmetic is modulo 2^WIDTH, and wrap is intentional and correct.
- Output: `d_out <= int[N−1][OUT_LSB+OUT_W−1 : OUT_LSB]`, truncation only, no rounding and no saturation.
- `d_valid` rises 2·R_eff+N+2 cycles after reset release. This is the length of the comb/integrator fill.
- `interpolation_ratio` changes between strobes have no effect until the next strobe. A ratio change causes a transient, and no correction is applied.
- Simultaneous strobe with `s_valid`: the sample is consumed. `s_valid` held high across non-strobe cycles is ignored. Upstream must hold `s_data` until the strobe.
- Reset values (applied regardless of `rst` arriving mid-operation):
  - `cnt` = 0
  - all comb delays, `stuff` and integrators = 0
  - `d_out` = 0, `d_valid` = 0, `s_ready` = 0, `underrun` = 0
- First strobe after reset occurs at cycle R−1 after reset release, with R = max(`interpolation_ratio` at release, 2).

## Timing
- Sample accepted at strobe cycle t:
  - `stuff` is valid at t+1.
  - `int[0]` reflects it at t+2 and `int[N−1]` at t+N+1.
  - `d_out` first reflects it at t+N+2 (t+5 for N=3).
- Throughput: one input per R cycles, one output per cycle.
- No combinational path from `s_valid` to `s_ready`. `s_ready` is purely a function of `cnt`.
- Critical path is a WIDTH-bit adder, one per integrator. The comb chain is N adders deep, but it is only sampled one cycle after the strobe, which allows a multicycle constraint if needed.

## Structure
- A shared SDR package holds default widths (`IN_W`, `OUT_W`, `WIDTH`) and a helper that computes `OUT_LSB` from N and log2(R). The receive-side CIC and this block use the same package.
- The integrator stage (register + adder, parameterised by WIDTH) is one natural sub-module, `cic_integrator`, instantiated N times. Combs stay inline.

## Test plan
- DC: `s_data` = 100 on every strobe, R=1024 → after settling, `d_out` = 100 constant (± 1 LSB), `underrun` = 0.
- Impulse: one sample = 127, then zeros, R=16, OUT_LSB=8 → `d_out` matches a bit-exact golden model cycle by cycle and returns to 0 after 3·16+5 cycles.
- Underrun: `s_valid` low on one strobe → `underrun` = 1 from the next cycle and stays 1; zero is inserted; the output matches the model with a 0 sample.
- Handshake: `s_valid` held high continuously, R=8 → exactly one sample is consumed every 8 cycles; `s_ready` is a single-cycle pulse at `cnt` = 7.
- Ratio edge: `interpolation_ratio` = 1, then 0 → `s_ready` period is 2; changing to 4 mid-period takes effect only after the next strobe.
- Reset mid-stream: assert `rst` during a full-scale −128 burst → the next cycle shows all outputs at reset values; after release, `s_ready` first pulses at cycle R−1.
